mem_bank_ctrl: RTL

Parametrised, handshaked successor to the flat DRAM bank. It stores DATA_BYTES-wide words and accepts byte-granular reads and writes of 1..DATA_BYTES bytes at any byte address. Accesses that cross a word boundary are split automatically into two internal beats, and read data is returned right-aligned after a configurable latency. It sits between the memory-side arbiter and the backing storage on the clk_mem domain.

---
 rtl/mem_bank_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: byte-granular, handshaked memory bank on the clk_mem domain.
// Stores DATA_BYTES-wide words. Accepts reads/writes of 1..DATA_BYTES bytes at any
// byte address. An access that crosses a word boundary is split into two internal
// beats, and the top word wraps to word 0. Read data comes back right-aligned,
// RD_LAT cycles after the final beat. Only one request is in flight at a time.
//
// Ports:
//   clk_mem    bank clock, rising edge
//   rst        asynchronous active-high reset (storage is not cleared)
//   req_valid  request present
//   req_ready  request accepted when high (IDLE only)
//   req_wr     1 = write, 0 = read
//   req_addr   byte address, any alignment
//   req_size   access length in bytes minus 1
//   req_wdata  right-aligned write data; bytes above req_size are ignored
//   rsp_valid  one-cycle completion pulse for reads and writes
//   rsp_rdata  right-aligned read data, zero above size, zero for writes; held
module mem_bank_ctrl #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned SIZE_W     = 3
) (
    input  logic                    clk_mem,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [SIZE_W-1:0]       req_size,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata
);
    localparam int unsigned W      = 8 * DATA_BYTES;
    localparam int unsigned WORD_W = ADDR_W - SIZE_W;
    localparam int unsigned DEPTH  = 2 ** WORD_W;
    localparam int unsigned CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [2:0] {StIdle, StBeat0, StBeat1, StWait, StResp} state_e;

    // With RD_LAT == 1 the WAIT state is skipped entirely.
    localparam state_e AFTER_BEATS = (RD_LAT == 1) ? StResp : StWait;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SIZE_W-1:0]   size_q;
    logic [W-1:0]        wdata_q;
    logic [W-1:0]        rdata_q;
    logic [W-1:0]        rd0_q, rd1_q;
    logic [W-1:0]        mem [DEPTH];

    logic [WORD_W-1:0]   w, w1;
    logic [SIZE_W-1:0]   off;
    logic [SIZE_W:0]     byte_end;
    logic [SIZE_W:0]     back;
    logic                split;
    logic [DATA_BYTES-1:0] be0, be1, rmask;
    logic [W-1:0]        wd0, wd1;
    logic [2*W-1:0]      rd_shift;
    logic [W-1:0]        rd_aligned;
    logic [W-1:0]        rsp_word;

    // Address decode from the registered request.
    assign w        = addr_q[ADDR_W-1:SIZE_W];
    assign w1       = w + WORD_W'(1);  // natural wrap of the top word to word 0
    assign off      = addr_q[SIZE_W-1:0];
    assign byte_end = {1'b0, off} + {1'b0, size_q};
    assign split    = byte_end[SIZE_W];
    assign back     = (SIZE_W + 1)'(DATA_BYTES) - {1'b0, off};
    assign wd0      = wdata_q << {off, 3'b000};
    assign wd1      = wdata_q >> {back, 3'b000};
    assign rd_shift = {rd1_q, rd0_q} >> {off, 3'b000};

    // Byte enables for each beat and the response byte mask. Masking by byte
    // range also discards wdata bytes above the access size.
    always_comb begin
        be0        = '0;
        be1        = '0;
        rmask      = '0;
        rd_aligned = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            be0[i]   = (i >= int'(off)) && (i <= int'(byte_end));
            be1[i]   = split && (i <= int'(byte_end[SIZE_W-1:0]));
            rmask[i] = (i <= int'(size_q));
            rd_aligned[8*i +: 8] = rmask[i] ? rd_shift[8*i +: 8] : 8'h00;
        end
    end

    assign rsp_word = wr_q ? '0 : rd_aligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = StBeat0;
            StBeat0: begin
                state_d = split ? StBeat1 : AFTER_BEATS;
                cnt_d   = '0;
            end
            StBeat1: begin
                state_d = AFTER_BEATS;
                cnt_d   = '0;
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) state_d = StResp;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req_valid) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
            end
            if (state_q == StResp) rdata_q <= rsp_word;
        end
    end

    // Storage and beat capture. No reset: contents survive rst, and an async
    // reset forces state_q to IDLE so an aborted beat never writes.
    always_ff @(posedge clk_mem) begin
        if (state_q == StBeat0) begin
            rd0_q <= mem[w];
            if (wr_q) begin
                for (int i = 0; i < int'(DATA_BYTES); i++) begin
                    if (be0[i]) mem[w][8*i +: 8] <= wd0[8*i +: 8];
                end
            end
        end
        if (state_q == StBeat1) begin
            rd1_q <= mem[w1];
            if (wr_q) begin
                for (int i = 0; i < int'(DATA_BYTES); i++) begin
                    if (be1[i]) mem[w1][8*i +: 8] <= wd1[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = (state_q == StResp) ? rsp_word : rdata_q;

endmodule
